usb_fifo_avalon_master: RTL

//  Avalon-MM initiator that drives the USB host/slave core's 8-bit register port.
//  It runs commanded block transfers against one fixed register address, typically
//  a FIFO data register. Reads are drained into a valid/ready byte stream, and

---
 rtl/usb_fifo_avalon_master.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/usb_fifo_avalon_master.sv
// Avalon-MM initiator running fixed-address block transfers against the USB core's
// 8-bit register port, bridging bus reads/writes to valid/ready byte streams.
module usb_fifo_avalon_master #(
    parameter int LEN_WIDTH      = 7,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmdValid,
    output logic                 cmdReady,
    input  logic                 cmdWrite,
    input  logic [7:0]           cmdAddr,
    input  logic [LEN_WIDTH-1:0] cmdLen,
    output logic [7:0]           avmAddress,
    output logic [7:0]           avmWritedata,
    input  logic [7:0]           avmReaddata,
    output logic                 avmRead,
    output logic                 avmWrite,
    output logic                 avmChipselect,
    input  logic                 avmWaitrequest,
    input  logic [7:0]           txData,
    input  logic                 txValid,
    output logic                 txReady,
    output logic [7:0]           rxData,
    output logic                 rxValid,
    input  logic                 rxReady,
    output logic                 busy,
    output logic                 done,
    output logic                 timeoutErr
);

    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE  = TIMEOUT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_ZERO = {TIMEOUT_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]     LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]     LEN_ZERO = {LEN_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ACCESS  = 3'd2,
        S_DELIVER = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [7:0]             r_addr;
    logic [7:0]             r_wdata;
    logic [7:0]             r_rxdata;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic [TIMEOUT_WIDTH-1:0] r_tmo_cnt;
    logic                   r_write;
    logic                   r_timeout_err;
    logic                   w_accept;
    logic                   w_complete;
    logic                   w_timeout;
    logic                   w_last;

    assign w_accept   = (r_state == S_IDLE) && cmdValid;
    assign w_complete = (r_state == S_ACCESS) && !avmWaitrequest;
    assign w_timeout  = (r_state == S_ACCESS) && avmWaitrequest && (r_tmo_cnt == TMO_LAST);
    // The access now completing is the final one when at most one byte remains.
    assign w_last     = (r_remaining <= LEN_ONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmdLen == LEN_ZERO) begin
                        w_next_state = S_DONE;
                    end else if (cmdWrite) begin
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_ACCESS;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_FETCH: begin
                if (txValid) begin
                    w_next_state = S_ACCESS;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_ACCESS: begin
                if (w_timeout) begin
                    w_next_state = S_DONE;
                end else if (w_complete) begin
                    if (!r_write) begin
                        w_next_state = S_DELIVER;
                    end else if (w_last) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end else begin
                    w_next_state = S_ACCESS;
                end
            end
            S_DELIVER: begin
                if (rxReady) begin
                    if (r_remaining == LEN_ZERO) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_ACCESS;
                    end
                end else begin
                    w_next_state = S_DELIVER;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        cmdReady      = 1'b0;
        txReady       = 1'b0;
        avmChipselect = 1'b0;
        avmRead       = 1'b0;
        avmWrite      = 1'b0;
        rxValid       = 1'b0;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmdReady = 1'b1;
            end
            S_FETCH: begin
                txReady = 1'b1;
            end
            S_ACCESS: begin
                avmChipselect = 1'b1;
                avmRead       = !r_write;
                avmWrite      = r_write;
            end
            S_DELIVER: begin
                rxValid = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                cmdReady = 1'b0;
            end
        endcase
    end

    assign busy         = (r_state != S_IDLE);
    assign avmAddress   = r_addr;
    assign avmWritedata = r_wdata;
    assign rxData       = r_rxdata;
    assign timeoutErr   = r_timeout_err;

    // Command latch, byte holding registers, remaining count and bus-wait timer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr        <= 8'h00;
            r_wdata       <= 8'h00;
            r_rxdata      <= 8'h00;
            r_remaining   <= LEN_ZERO;
            r_write       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_tmo_cnt     <= TMO_ZERO;
        end else begin
            if (w_accept) begin
                r_addr        <= cmdAddr;
                r_write       <= cmdWrite;
                r_remaining   <= cmdLen;
                r_timeout_err <= 1'b0;
            end
            if ((r_state == S_FETCH) && txValid) begin
                r_wdata <= txData;
            end
            if (w_complete) begin
                if (r_remaining != LEN_ZERO) begin
                    r_remaining <= r_remaining - LEN_ONE;
                end
                if (!r_write) begin
                    r_rxdata <= avmReaddata;
                end
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            // Held at zero outside ACCESS, so every ACCESS entry starts a fresh count.
            if (r_state != S_ACCESS) begin
                r_tmo_cnt <= TMO_ZERO;
            end else if (avmWaitrequest) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
            end
        end
    end

endmodule
